// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and helpers for the instruction fetch stage.
//   BR_SEQ / BR_JUMP  : values of the 2-bit branch select S
//   BR_REL_MSB        : bit of S that selects a PC-relative redirect
//   rel_offset()      : sign-extends the split 6-bit branch offset
//                       {inst[8:6], inst[2:0]} to 32 bits
package fetch_pkg;

  localparam logic [1:0] BR_SEQ     = 2'b00;
  localparam logic [1:0] BR_JUMP    = 2'b01;
  localparam int         BR_REL_MSB = 1;

  function automatic logic [31:0] rel_offset(input logic [8:0] inst);
    logic [5:0] off;
    off = {inst[8:6], inst[2:0]};
    return {{26{off[5]}}, off};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of {pc, instruction} words.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : write one entry (ignored only if full without pop)
//   pop               : remove the head entry
//   flush             : empty the queue (wins over push/pop)
//   head_data         : head entry, read straight from storage flops
//   head_valid        : queue holds at least one entry
//   count             : number of entries held
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s     = (count_r == CW'(DEPTH));
  assign do_pop_s   = pop & (count_r != {CW{1'b0}});
  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_push_s  = push & (~full_s | do_pop_s);
  assign head_data  = mem_r[rd_ptr_r];
  assign head_valid = (count_r != {CW{1'b0}});
  assign count      = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction fetch stage.
//   CLK, RESET             : clock, asynchronous active-high reset
//   IMEM_REQ/ADDR/GNT      : in-order request handshake to instruction memory
//   IMEM_RVALID/RDATA      : in-order read responses, one per grant
//   INST/INST_PC/VALID     : head of the prefetch queue towards the decoder
//   INST_READY             : decoder consumes the head
//   S, JA                  : branch select and absolute target, used on consume
//   PERF_FLUSH_CNT         : saturating redirect count     (FETCH_PERF_EN only)
//   PERF_BUBBLE_CNT        : saturating empty-cycle count  (FETCH_PERF_EN only)
// Build option: define FETCH_PERF_EN to add the two performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic          IMEM_REQ,
  output logic [AW-1:0] IMEM_ADDR,
  input  logic          IMEM_GNT,
  input  logic          IMEM_RVALID,
  input  logic [DW-1:0] IMEM_RDATA,
  output logic [DW-1:0] INST,
  output logic [AW-1:0] INST_PC,
  output logic          INST_VALID,
  input  logic          INST_READY,
`ifdef FETCH_PERF_EN
  output logic [15:0]   PERF_FLUSH_CNT,
  output logic [15:0]   PERF_BUBBLE_CNT,
`endif
  input  logic [1:0]    S,
  input  logic [AW-1:0] JA
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [AW-1:0]    fetch_pc_r, fetch_pc_nx_s;
  logic [AW-1:0]    resp_pc_r, resp_pc_nx_s;
  logic [CW-1:0]    outstanding_r, outstanding_nx_s;
  logic [CW-1:0]    discard_r, discard_nx_s;
  logic [CW-1:0]    q_count_s;
  logic [AW+DW-1:0] head_s;
  logic [DW-1:0]    head_inst_s;
  logic [AW-1:0]    head_pc_s;
  logic [AW-1:0]    target_s;
  logic             q_valid_s;
  logic             room_s, consume_s, redirect_s;
  logic             grant_s, resp_s, push_s;

  assign head_inst_s = head_s[DW-1:0];
  assign head_pc_s   = head_s[AW+DW-1:DW];

  // Words queued plus words still owed by memory never exceed the queue size,
  // so every response always has a slot waiting for it.
  assign room_s     = ({1'b0, q_count_s} + {1'b0, outstanding_r}) < DEPTH_W;
  assign consume_s  = q_valid_s & INST_READY;
  assign redirect_s = consume_s & (S != BR_SEQ);
  assign IMEM_REQ   = room_s & ~redirect_s & ~RESET;
  assign IMEM_ADDR  = fetch_pc_r;
  assign grant_s    = IMEM_REQ & IMEM_GNT;
  assign resp_s     = IMEM_RVALID & (outstanding_r != {CW{1'b0}});
  assign push_s     = resp_s & (discard_r == {CW{1'b0}}) & ~redirect_s;

  assign INST       = q_valid_s ? head_inst_s : {DW{1'b0}};
  assign INST_PC    = q_valid_s ? head_pc_s : {AW{1'b0}};
  assign INST_VALID = q_valid_s;

  // Redirect target from the head instruction and the branch select.
  always_comb begin
    target_s = head_pc_s;
    if (S[BR_REL_MSB]) begin
      target_s = AW'(32'(head_pc_s) + rel_offset(head_inst_s[8:0]));
    end else if (S == BR_JUMP) begin
      target_s = JA;
    end else begin
      target_s = head_pc_s;
    end
  end

  // Outstanding-request count after this cycle's grant and response.
  always_comb begin
    outstanding_nx_s = outstanding_r;
    case ({grant_s, resp_s})
      2'b10:   outstanding_nx_s = outstanding_r + CW'(1'b1);
      2'b01:   outstanding_nx_s = outstanding_r - CW'(1'b1);
      default: outstanding_nx_s = outstanding_r;
    endcase
  end

  // Next fetch/response PCs and discard count; a redirect drops every
  // request still owed, including any response arriving this cycle.
  always_comb begin
    fetch_pc_nx_s = fetch_pc_r;
    resp_pc_nx_s  = resp_pc_r;
    discard_nx_s  = discard_r;
    if (redirect_s) begin
      fetch_pc_nx_s = target_s;
      resp_pc_nx_s  = target_s;
      discard_nx_s  = outstanding_nx_s;
    end else begin
      if (grant_s) begin
        fetch_pc_nx_s = fetch_pc_r + AW'(1'b1);
      end else begin
        fetch_pc_nx_s = fetch_pc_r;
      end
      if (resp_s && (discard_r != {CW{1'b0}})) begin
        discard_nx_s = discard_r - CW'(1'b1);
      end else if (push_s) begin
        resp_pc_nx_s = resp_pc_r + AW'(1'b1);
      end else begin
        discard_nx_s = discard_r;
      end
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_nx_s;
      resp_pc_r     <= resp_pc_nx_s;
      outstanding_r <= outstanding_nx_s;
      discard_r     <= discard_nx_s;
    end
  end

  fetch_queue #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (CLK),
    .rst        (RESET),
    .push       (push_s),
    .push_data  ({resp_pc_r, IMEM_RDATA}),
    .pop        (consume_s),
    .flush      (redirect_s),
    .head_data  (head_s),
    .head_valid (q_valid_s),
    .count      (q_count_s)
  );

`ifdef FETCH_PERF_EN
  // Saturating redirect and empty-head counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PERF_FLUSH_CNT  <= 16'h0000;
      PERF_BUBBLE_CNT <= 16'h0000;
    end else begin
      if (redirect_s && (PERF_FLUSH_CNT != 16'hFFFF)) begin
        PERF_FLUSH_CNT <= PERF_FLUSH_CNT + 16'h0001;
      end else begin
        PERF_FLUSH_CNT <= PERF_FLUSH_CNT;
      end
      if (!q_valid_s && (PERF_BUBBLE_CNT != 16'hFFFF)) begin
        PERF_BUBBLE_CNT <= PERF_BUBBLE_CNT + 16'h0001;
      end else begin
        PERF_BUBBLE_CNT <= PERF_BUBBLE_CNT;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with an in-order memory
// model and a program-flow reference (expected PC sequence of consumed
// instructions computed from the branch rules). Define FETCH_PERF_EN to
// also check the performance counters.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [15:0] IMEM_RDATA = 16'h0000;
  logic [15:0] INST;
  logic [15:0] INST_PC;
  logic        INST_VALID;
  logic        INST_READY = 1'b0;
  logic [1:0]  S = 2'b00;
  logic [15:0] JA = 16'h0000;
`ifdef FETCH_PERF_EN
  logic [15:0] PERF_FLUSH_CNT;
  logic [15:0] PERF_BUBBLE_CNT;
`endif

  fetch_unit dut (
    .CLK (CLK), .RESET (RESET),
    .IMEM_REQ (IMEM_REQ), .IMEM_ADDR (IMEM_ADDR), .IMEM_GNT (IMEM_GNT),
    .IMEM_RVALID (IMEM_RVALID), .IMEM_RDATA (IMEM_RDATA),
    .INST (INST), .INST_PC (INST_PC), .INST_VALID (INST_VALID),
    .INST_READY (INST_READY),
`ifdef FETCH_PERF_EN
    .PERF_FLUSH_CNT (PERF_FLUSH_CNT), .PERF_BUBBLE_CNT (PERF_BUBBLE_CNT),
`endif
    .S (S), .JA (JA)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc, first_valid, gnt_pct, rsp_pct, rdy_pct, lat_min, lat_max, br_mode;
  int bubbles, flushes;
  logic [15:0] exp_pc;
  logic [15:0] consumed[$];
  logic [15:0] g_addr[$];
  int          g_cyc[$];
  logic [15:0] pend_addr[$];
  int          pend_due[$];
  logic [15:0] plan_pc[$];
  logic [1:0]  plan_s[$];
  logic [15:0] plan_ja[$];
  logic        hold_v, req_pend;
  logic [15:0] hold_pc, hold_inst, req_addr;
  logic [15:0] img [int];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents: a few fixed words, otherwise a hash of the address.
  function automatic logic [15:0] word(input logic [15:0] a);
    if (img.exists(int'(a))) return img[int'(a)];
    return (a * 16'h9E37) ^ 16'hA5C3;
  endfunction

  // Architectural next PC after consuming instruction w at pc.
  function automatic logic [15:0] next_pc(input logic [15:0] pc, input logic [15:0] w,
                                          input logic [1:0] s, input logic [15:0] ja);
    int v, off;
    v   = int'({w[8:6], w[2:0]});
    off = (v >= 32) ? v - 64 : v;
    if (s == 2'b00) return pc + 16'h0001;
    if (s == 2'b01) return ja;
    return 16'((int'(pc) + off + 65536) % 65536);
  endfunction

  function automatic logic [31:0] at_c(input int i);
    if (i < consumed.size()) return {16'h0000, consumed[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] at_g(input int i);
    if (i < g_addr.size()) return {16'h0000, g_addr[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] at_gc(input int i);
    if (i < g_cyc.size()) return 32'(g_cyc[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_model();
    cyc = 0; first_valid = -1; exp_pc = 16'h0000;
    consumed.delete(); g_addr.delete(); g_cyc.delete();
    pend_addr.delete(); pend_due.delete();
    plan_pc.delete(); plan_s.delete(); plan_ja.delete();
    hold_v = 1'b0; req_pend = 1'b0; bubbles = 0; flushes = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_req"}, IMEM_REQ, 0);
    check_eq({tag, "_addr"}, IMEM_ADDR, 0);
    check_eq({tag, "_valid"}, INST_VALID, 0);
    check_eq({tag, "_inst"}, INST, 0);
    check_eq({tag, "_pc"}, INST_PC, 0);
`ifdef FETCH_PERF_EN
    check_eq({tag, "_perf_flush"}, PERF_FLUSH_CNT, 0);
    check_eq({tag, "_perf_bubble"}, PERF_BUBBLE_CNT, 0);
`endif
  endtask

  task automatic do_reset();
    RESET = 1'b1; INST_READY = 1'b0; S = 2'b00; JA = 16'h0000;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 16'h0000;
    repeat (2) @(negedge CLK);
    #1;
    check_outputs_zero("rst");
    @(negedge CLK);
    RESET = 1'b0;
    clear_model();
  endtask

  task automatic set_mem(input int gp, input int rp, input int lmin, input int lmax);
    gnt_pct = gp; rsp_pct = rp; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic add_plan(input logic [15:0] pc, input logic [1:0] s, input logic [15:0] ja);
    plan_pc.push_back(pc); plan_s.push_back(s); plan_ja.push_back(ja);
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1 time unit later.
  task automatic step();
    logic cons, redir, granted;
    INST_READY = ($urandom_range(99) < rdy_pct);
    S  = 2'b00;
    JA = 16'($urandom);
    if (br_mode == 2) S = 2'($urandom_range(3));
    if (INST_VALID && INST_READY) begin
      if (br_mode == 1) begin
        if (plan_pc.size() > 0 && INST_PC == plan_pc[0]) begin
          S = plan_s[0]; JA = plan_ja[0];
          void'(plan_pc.pop_front()); void'(plan_s.pop_front()); void'(plan_ja.pop_front());
        end else begin
          S = 2'b00;
        end
      end else if (br_mode == 2) begin
        if ($urandom_range(99) >= 15) S = 2'b00;
      end
    end
    IMEM_RVALID = 1'b0;
    IMEM_RDATA  = 16'($urandom);
    if (pend_addr.size() > 0 && pend_due[0] <= cyc && $urandom_range(99) < rsp_pct) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = word(pend_addr[0]);
      void'(pend_addr.pop_front()); void'(pend_due.pop_front());
    end
    IMEM_GNT = ($urandom_range(99) < gnt_pct);
    #1;
    cons    = INST_VALID && INST_READY;
    redir   = cons && (S != 2'b00);
    granted = IMEM_REQ && IMEM_GNT;
    if (redir) check_eq("req_in_redirect", IMEM_REQ, 0);
    if (req_pend && !redir) begin
      check_eq("req_hold", IMEM_REQ, 1);
      check_eq("addr_hold", IMEM_ADDR, req_addr);
    end
    req_pend = IMEM_REQ && !IMEM_GNT;
    req_addr = IMEM_ADDR;
    if (hold_v) begin
      check_eq("head_hold_valid", INST_VALID, 1);
      check_eq("head_hold_pc", INST_PC, hold_pc);
      check_eq("head_hold_inst", INST, hold_inst);
    end
    hold_v = INST_VALID && !INST_READY; hold_pc = INST_PC; hold_inst = INST;
    if (INST_VALID && first_valid < 0) first_valid = cyc;
    if (cons) begin
      check_eq("flow_pc", INST_PC, exp_pc);
      check_eq("flow_inst", INST, word(exp_pc));
      consumed.push_back(INST_PC);
      exp_pc = next_pc(exp_pc, word(exp_pc), S, JA);
    end
    if (granted) begin
      g_addr.push_back(IMEM_ADDR); g_cyc.push_back(cyc);
      pend_addr.push_back(IMEM_ADDR);
      pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      check_eq("outstanding_bound", pend_addr.size() <= 4, 1);
    end
`ifdef FETCH_PERF_EN
    check_eq("perf_bubble", PERF_BUBBLE_CNT, bubbles);
    check_eq("perf_flush", PERF_FLUSH_CNT, flushes);
    if (!INST_VALID) bubbles++;
    if (redir) flushes++;
`endif
    @(negedge CLK);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    img[0]        = 16'h01C6;  // offset field 6'b111110 = -2
    img[16'h0010] = 16'h01C6;
    clear_model();
    br_mode = 0; rdy_pct = 100; set_mem(100, 100, 1, 1);

    // Sequential fetch with zero-wait memory.
    do_reset();
    run(8);
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_addr", at_g(i), 32'(i));
      check_eq("seq_gnt_cycle", at_gc(i), 32'(i));
    end
    check_eq("first_valid_cycle", 32'(first_valid), 32'd2);
    for (int i = 0; i < 3; i++) check_eq("seq_inst_pc", at_c(i), 32'(i));

    // Decoder stalled: only DEPTH requests, head held on PC 0.
    do_reset();
    rdy_pct = 0;
    run(10);
    check_eq("stall_grants", 32'(g_addr.size()), 32'd4);
    check_eq("stall_req_low", IMEM_REQ, 0);
    check_eq("stall_valid", INST_VALID, 1);
    check_eq("stall_pc", INST_PC, 16'h0000);
    check_eq("stall_inst", INST, word(16'h0000));
    rdy_pct = 100;
    run(10);
    for (int i = 0; i < 4; i++) check_eq("stall_release_pc", at_c(i), 32'(i));
    check_eq("stall_resume_addr", at_g(4), 32'd4);

    // Absolute jump at PC 5 with responses in flight.
    do_reset();
    br_mode = 1; set_mem(100, 100, 2, 2);
    add_plan(16'h0005, 2'b01, 16'h0040);
    run(30);
    check_eq("jump_pre_pc", at_c(5), 32'h5);
    check_eq("jump_target_pc", at_c(6), 32'h40);

    // Relative branches: 0x10-2 = 0x0E, then jump to 0 and 0-2 wraps.
    do_reset();
    br_mode = 1; set_mem(100, 100, 1, 1);
    add_plan(16'h0010, 2'b10, 16'h1234);
    add_plan(16'h000F, 2'b01, 16'h0000);
    add_plan(16'h0000, 2'b11, 16'h5678);
    run(45);
    check_eq("rel_back_pc", at_c(17), 32'h000E);
    check_eq("rel_jump_zero", at_c(19), 32'h0000);
    check_eq("rel_wrap_pc", at_c(20), 32'hFFFE);

    // Redirect while a response arrives and GNT is high.
    do_reset();
    br_mode = 1; set_mem(100, 100, 1, 1);
    add_plan(16'h0003, 2'b01, 16'h0100);
    run(20);
    check_eq("same_cycle_pre", at_c(3), 32'h3);
    check_eq("same_cycle_target", at_c(4), 32'h100);

    // Reset mid-stream with a full queue.
    do_reset();
    br_mode = 0; rdy_pct = 0; set_mem(100, 100, 1, 1);
    run(8);
    check_eq("pre_rst_valid", INST_VALID, 1);
    #2 RESET = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    clear_model();
    br_mode = 1; rdy_pct = 100;
    add_plan(16'h0001, 2'b01, 16'h0020);
    add_plan(16'h0021, 2'b01, 16'h0080);
    run(30);
    check_eq("post_rst_addr", at_g(0), 32'h0);
    check_eq("post_rst_gnt_cycle", at_gc(0), 32'd0);
    check_eq("post_rst_jump1", at_c(2), 32'h20);
    check_eq("post_rst_jump2", at_c(4), 32'h80);
`ifdef FETCH_PERF_EN
    check_eq("perf_two_flushes", PERF_FLUSH_CNT, 2);
`endif

    // Randomized traffic: variable grants, latency, stalls and branches.
    do_reset();
    br_mode = 2; rdy_pct = 70; set_mem(70, 70, 1, 4);
    run(3000);
    check_eq("random_progress", consumed.size() > 300, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
